vga_text_writer: RTL and testbench
==================================

Name: vga_text_writer

Overview:
- Writer side of the text-mode VGA character-buffer write port (DATA_ADDR / DATA_IN / WR_EN).
- Accepts a valid/ready stream of 8-bit character codes and turns it into buffer writes. Maintains a cursor and interprets control codes: CR, LF, BS, FF.
- Clears a row when the cursor enters it, and clears the whole screen on FF and after reset.
- Sits between a character source (UART receiver, CPU port) and the VGA top.

Parameters:
- DATA_ADDR_WIDTH, 6, width of the buffer address; COLS*ROWS must be <= 2**DATA_ADDR_WIDTH.
- COLS, 8, characters per row.
- ROWS, 8, rows per screen.
- CLEAR_ON_RESET, 1, when 1 a full-screen clear runs immediately after reset release.

Ports:
- CLK  in  1  single clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- CHAR_IN  in  8  character code from the source.
- CHAR_VALID  in  1  CHAR_IN is valid.
- CHAR_READY  out  1  block can accept a character this cycle.
- DATA_ADDR  out  DATA_ADDR_WIDTH  buffer write address (to VGA DATA_ADDR).
- DATA_OUT  out  8  buffer write data (to VGA DATA_IN).
- WR_EN  out  1  buffer write strobe, one cell per cycle.
- CURSOR  out  DATA_ADDR_WIDTH  current cursor cell address.
- BUSY  out  1  a clear sequence is in progress.

Behaviour:
- Reset (RESET=0, asynchronous):
  - WR_EN=0, DATA_ADDR=0, DATA_OUT=0, CURSOR=0, internal row/col = 0.
  - State goes to CLEAR_ALL if CLEAR_ON_RESET=1, else IDLE.
  - Reset mid-sequence aborts it; no WR_EN until reset is released.
- Addressing:
  - Cursor is kept as col (0..COLS-1), row (0..ROWS-1) and row_base = row*COLS.
  - row_base is updated by adding or subtracting COLS; no multiplier.
  - CURSOR = row_base + col.
- DATA_ADDR, DATA_OUT and WR_EN are registered. A write appears the cycle after its cause.
- CHAR_READY = (state==IDLE), combinational. BUSY = (state!=IDLE). A character is accepted when CHAR_VALID && CHAR_READY.
- States: IDLE, CLEAR_ROW, CLEAR_ALL.
- IDLE, accepted character:
  - Printable 0x20..0x7E: next cycle WR_EN=1, DATA_ADDR=CURSOR, DATA_OUT=char. Cursor advances by one.
    - If col was COLS-1: col=0, row increments (row ROWS-1 wraps to 0), state goes to CLEAR_ROW.
    - Otherwise stays in IDLE.
    - Sustained throughput: 1 char/cycle within a row.
  - 0x0D (CR): col=0; no write; stay in IDLE.
  - 0x0A (LF): col=0, row increments with wrap; no char write; go to CLEAR_ROW.
  - 0x08 (BS): if col>0, col decrements and next cycle writes 0x20 at the new cursor. If col==0, no-op (no write, no move).
  - 0x0C (FF): cursor=0; go to CLEAR_ALL.
  - Any other code (0x00..0x1F not listed above, 0x7F..0xFF): consumed, no write, no cursor change.
- CLEAR_ROW:
  - Issues COLS consecutive writes, one per cycle, of 0x20 to row_base+0 .. row_base+COLS-1 of the new row.
  - Then returns to IDLE. Cursor remains at col 0.
  - The first clear write is on the cycle after the triggering character's own write, or the cycle after acceptance for LF.
- CLEAR_ALL:
  - Issues COLS*ROWS consecutive writes of 0x20, addresses 0 .. COLS*ROWS-1.
  - Then returns to IDLE with cursor=0.
- WR_EN is 0 in every cycle not described above.
- DATA_ADDR and DATA_OUT hold their last values when WR_EN=0.
- No scrolling: content wraps to row 0 and each row is cleared on entry.
- An internal clear counter of width DATA_ADDR_WIDTH+1 avoids overflow when COLS*ROWS = 2**DATA_ADDR_WIDTH.

Test Plan:
- Reset release, CLEAR_ON_RESET=1 (COLS=8, ROWS=8):
  - WR_EN high for 64 consecutive cycles, addr 0..63, data 0x20.
  - BUSY=1 and CHAR_READY=0 throughout; then CURSOR=0, CHAR_READY=1.
- Stream "HI" back-to-back from cursor 0:
  - WR_EN on two consecutive cycles: (addr 0, 0x48), (addr 1, 0x49).
  - CURSOR=2; CHAR_READY never drops.
- Row wrap:
  - Cursor at 7, send 'A' → (7, 0x41), then 8 writes of 0x20 to addrs 8..15.
  - CURSOR=8; CHAR_READY=0 for exactly those 8 cycles.
- Screen wrap and LF at last row:
  - Cursor at 63, send 'Z' → (63, 0x5A), then clear addrs 0..7, CURSOR=0.
  - Cursor 58 (row 7), send LF → no char write, clear 0..7, CURSOR=0.
- Control codes:
  - Cursor 19, send CR → CURSOR=16, no WR_EN.
  - Send BS at 19 → write (18, 0x20), CURSOR=18.
  - BS at 16 → no-op.
  - 0x07 → consumed, no write.
- FF mid-screen, then reset asserted during the clear:
  - Cursor 30, send FF → 64-write clear starts at addr 0.
  - Assert RESET at clear index 20 → WR_EN=0 and all outputs 0 asynchronously.
  - Release → clear restarts from addr 0.

Source files
------------

// File: rtl/vga_text_writer_if.sv
// Character-stream and buffer-write signals of the text-mode VGA writer.
// The master drives characters in; the slave (the writer) drives buffer writes and status out.
interface vga_text_writer_if #(
  parameter int DATA_ADDR_WIDTH = 6
);
  logic [7:0]                 char_in;
  logic                       char_valid;
  logic                       char_ready;
  logic [DATA_ADDR_WIDTH-1:0] data_addr;
  logic [7:0]                 data_out;
  logic                       wr_en;
  logic [DATA_ADDR_WIDTH-1:0] cursor;
  logic                       busy;

  modport master (
    output char_in, char_valid,
    input  char_ready, data_addr, data_out, wr_en, cursor, busy
  );

  modport slave (
    input  char_in, char_valid,
    output char_ready, data_addr, data_out, wr_en, cursor, busy
  );
endinterface

// File: rtl/vga_text_writer.sv
// Turns a valid/ready stream of character codes into text-buffer writes.
// It keeps a cursor, handles CR/LF/BS/FF, and clears each row as the cursor enters it.
module vga_text_writer #(
  parameter int DATA_ADDR_WIDTH = 6,
  parameter int COLS            = 8,
  parameter int ROWS            = 8,
  parameter bit CLEAR_ON_RESET  = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  vga_text_writer_if.slave bus
);
  localparam int AW    = DATA_ADDR_WIDTH;
  localparam int TOTAL = COLS * ROWS;
  localparam int CW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;

  localparam logic [7:0] SPACE = 8'h20;
  localparam logic [7:0] CH_BS = 8'h08;
  localparam logic [7:0] CH_LF = 8'h0A;
  localparam logic [7:0] CH_FF = 8'h0C;
  localparam logic [7:0] CH_CR = 8'h0D;

  typedef enum logic [1:0] {IDLE, CLEAR_ROW, CLEAR_ALL} state_t;

  state_t        state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [AW-1:0] row_base;
  logic [AW:0]   clr_cnt;
  logic [AW-1:0] data_addr;
  logic [7:0]    data_out;
  logic          wr_en;

  logic [AW-1:0] cursor;
  logic [AW-1:0] next_row_base;
  logic [RW-1:0] next_row;
  logic          last_col;
  logic          last_row;
  logic          accept;
  logic          printable;

  // row_base tracks row*COLS by stepping, so no multiplier is needed.
  assign cursor        = row_base + AW'(col);
  assign last_col      = (col == CW'(COLS - 1));
  assign last_row      = (row == RW'(ROWS - 1));
  assign next_row      = last_row ? '0 : row + RW'(1);
  assign next_row_base = last_row ? '0 : row_base + AW'(COLS);
  assign accept        = bus.char_valid && (state == IDLE);
  assign printable     = (bus.char_in >= 8'h20) && (bus.char_in <= 8'h7E);

  assign bus.char_ready = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.cursor     = cursor;
  assign bus.data_addr  = data_addr;
  assign bus.data_out   = data_out;
  assign bus.wr_en      = wr_en;

  // NOTE: all state here uses non-blocking assignments so every branch sees
  // the pre-edge values of col/row/row_base, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
      col       <= '0;
      row       <= '0;
      row_base  <= '0;
      clr_cnt   <= '0;
      data_addr <= '0;
      data_out  <= '0;
      wr_en     <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            if (printable) begin
              wr_en     <= 1'b1;
              data_addr <= cursor;
              data_out  <= bus.char_in;
              if (last_col) begin
                col      <= '0;
                row      <= next_row;
                row_base <= next_row_base;
                clr_cnt  <= '0;
                state    <= CLEAR_ROW;
              end else begin
                col <= col + CW'(1);
              end
            end else if (bus.char_in == CH_CR) begin
              col <= '0;
            end else if (bus.char_in == CH_LF) begin
              // The first clear write is issued straight away, so it lands
              // on the cycle after the LF is accepted.
              col       <= '0;
              row       <= next_row;
              row_base  <= next_row_base;
              wr_en     <= 1'b1;
              data_addr <= next_row_base;
              data_out  <= SPACE;
              clr_cnt   <= (AW+1)'(1);
              state     <= (COLS > 1) ? CLEAR_ROW : IDLE;
            end else if (bus.char_in == CH_BS) begin
              if (col != '0) begin
                col       <= col - CW'(1);
                wr_en     <= 1'b1;
                data_addr <= cursor - AW'(1);
                data_out  <= SPACE;
              end
            end else if (bus.char_in == CH_FF) begin
              col      <= '0;
              row      <= '0;
              row_base <= '0;
              clr_cnt  <= '0;
              state    <= CLEAR_ALL;
            end
          end
        end

        CLEAR_ROW: begin
          wr_en     <= 1'b1;
          data_addr <= row_base + clr_cnt[AW-1:0];
          data_out  <= SPACE;
          if (clr_cnt == (AW+1)'(COLS - 1)) state <= IDLE;
          else clr_cnt <= clr_cnt + (AW+1)'(1);
        end

        CLEAR_ALL: begin
          wr_en     <= 1'b1;
          data_addr <= clr_cnt[AW-1:0];
          data_out  <= SPACE;
          if (clr_cnt == (AW+1)'(TOTAL - 1)) begin
            state    <= IDLE;
            col      <= '0;
            row      <= '0;
            row_base <= '0;
          end else begin
            clr_cnt <= clr_cnt + (AW+1)'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_text_writer.sv
// Directed bench for vga_text_writer on an 8x8 screen: reset clear, streaming,
// row/screen wrap, control codes, and reset during a form-feed clear.
module tb_vga_text_writer;
  localparam int AW   = 6;
  localparam int COLS = 8;
  localparam int ROWS = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  vga_text_writer_if #(.DATA_ADDR_WIDTH(AW)) bus ();

  vga_text_writer #(
    .DATA_ADDR_WIDTH(AW),
    .COLS           (COLS),
    .ROWS           (ROWS),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  int checks = 0;
  int errors = 0;
  bit stall_seen = 1'b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus helpers only; every comparison lives in the test tasks.
  task automatic wait_idle();
    int n = 0;
    while (bus.char_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) stall_seen = 1'b1;
  endtask

  task automatic send(input logic [7:0] c);
    bus.char_valid = 1'b1;
    bus.char_in    = c;
    @(negedge clk);
    bus.char_valid = 1'b0;
  endtask

  task automatic type_chars(input int n, input logic [7:0] c);
    for (int k = 0; k < n; k++) begin
      wait_idle();
      send(c);
    end
    wait_idle();
  endtask

  task automatic test_reset();
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b0, 6'd0, 8'h00, 6'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got wr_en=%b addr=%0d data=%h cursor=%0d expected 0 0 00 0",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
    checks++;
    if ({bus.busy, bus.char_ready} !== 2'b10) begin
      errors++;
      $display("FAIL reset_status: got busy=%b ready=%b expected busy=1 ready=0", bus.busy, bus.char_ready);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out} !== {1'b1, 6'(i), 8'h20}) begin
        errors++;
        $display("FAIL reset_clear[%0d]: got wr_en=%b addr=%0d data=%h expected 1 %0d 20",
                 i, bus.wr_en, bus.data_addr, bus.data_out, i);
      end
      if (i < 63) begin
        checks++;
        if ({bus.busy, bus.char_ready} !== 2'b10) begin
          errors++;
          $display("FAIL reset_clear_busy[%0d]: got busy=%b ready=%b expected 1 0", i, bus.busy, bus.char_ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.busy, bus.char_ready, bus.cursor} !== {1'b0, 1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL reset_done: got wr_en=%b busy=%b ready=%b cursor=%0d expected 0 0 1 0",
               bus.wr_en, bus.busy, bus.char_ready, bus.cursor);
    end
  endtask

  task automatic test_back_to_back();
    bus.char_valid = 1'b1;
    bus.char_in    = 8'h48;
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready} !== {1'b1, 6'd0, 8'h48, 1'b1}) begin
      errors++;
      $display("FAIL b2b_H: got wr_en=%b addr=%0d data=%h ready=%b expected 1 0 48 1",
               bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready);
    end
    bus.char_in = 8'h49;
    @(negedge clk);
    bus.char_valid = 1'b0;
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready, bus.cursor} !==
        {1'b1, 6'd1, 8'h49, 1'b1, 6'd2}) begin
      errors++;
      $display("FAIL b2b_I: got wr_en=%b addr=%0d data=%h ready=%b cursor=%0d expected 1 1 49 1 2",
               bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready, bus.cursor);
    end
  endtask

  task automatic test_row_wrap();
    type_chars(5, 8'h61);
    checks++;
    if (bus.cursor !== 6'd7) begin
      errors++;
      $display("FAIL row_wrap_setup: got cursor=%0d expected 7", bus.cursor);
    end
    send(8'h41);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready, bus.cursor} !==
        {1'b1, 6'd7, 8'h41, 1'b0, 6'd8}) begin
      errors++;
      $display("FAIL row_wrap_char: got wr_en=%b addr=%0d data=%h ready=%b cursor=%0d expected 1 7 41 0 8",
               bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready, bus.cursor);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready} !== {1'b1, 6'(8 + i), 8'h20, (i == 7)}) begin
        errors++;
        $display("FAIL row_wrap_clear[%0d]: got wr_en=%b addr=%0d data=%h ready=%b expected 1 %0d 20 %0d",
                 i, bus.wr_en, bus.data_addr, bus.data_out, bus.char_ready, 8 + i, (i == 7));
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.cursor} !== {1'b0, 6'd8}) begin
      errors++;
      $display("FAIL row_wrap_end: got wr_en=%b cursor=%0d expected 0 8", bus.wr_en, bus.cursor);
    end
  endtask

  task automatic test_screen_wrap();
    type_chars(55, 8'h62);
    checks++;
    if (bus.cursor !== 6'd63) begin
      errors++;
      $display("FAIL screen_wrap_setup: got cursor=%0d expected 63", bus.cursor);
    end
    send(8'h5A);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b1, 6'd63, 8'h5A, 6'd0}) begin
      errors++;
      $display("FAIL screen_wrap_char: got wr_en=%b addr=%0d data=%h cursor=%0d expected 1 63 5a 0",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out} !== {1'b1, 6'(i), 8'h20}) begin
        errors++;
        $display("FAIL screen_wrap_clear[%0d]: got wr_en=%b addr=%0d data=%h expected 1 %0d 20",
                 i, bus.wr_en, bus.data_addr, bus.data_out, i);
      end
    end
    // Walk down to row 7 col 2 with LFs, then LF on the last row.
    wait_idle();
    type_chars(7, 8'h0A);
    type_chars(2, 8'h63);
    checks++;
    if (bus.cursor !== 6'd58) begin
      errors++;
      $display("FAIL lf_last_setup: got cursor=%0d expected 58", bus.cursor);
    end
    send(8'h0A);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b1, 6'(i), 8'h20, 6'd0}) begin
        errors++;
        $display("FAIL lf_last_clear[%0d]: got wr_en=%b addr=%0d data=%h cursor=%0d expected 1 %0d 20 0",
                 i, bus.wr_en, bus.data_addr, bus.data_out, bus.cursor, i);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.char_ready, bus.cursor} !== {1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL lf_last_end: got wr_en=%b ready=%b cursor=%0d expected 0 1 0",
               bus.wr_en, bus.char_ready, bus.cursor);
    end
  endtask

  task automatic test_control_codes();
    type_chars(2, 8'h0A);
    type_chars(3, 8'h64);
    send(8'h0D);
    checks++;
    if ({bus.wr_en, bus.cursor} !== {1'b0, 6'd16}) begin
      errors++;
      $display("FAIL cr: got wr_en=%b cursor=%0d expected 0 16", bus.wr_en, bus.cursor);
    end
    type_chars(3, 8'h65);
    send(8'h08);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b1, 6'd18, 8'h20, 6'd18}) begin
      errors++;
      $display("FAIL bs: got wr_en=%b addr=%0d data=%h cursor=%0d expected 1 18 20 18",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
    send(8'h0D);
    send(8'h08);
    checks++;
    if ({bus.wr_en, bus.cursor} !== {1'b0, 6'd16}) begin
      errors++;
      $display("FAIL bs_col0: got wr_en=%b cursor=%0d expected 0 16", bus.wr_en, bus.cursor);
    end
    send(8'h07);
    checks++;
    if ({bus.wr_en, bus.char_ready, bus.cursor} !== {1'b0, 1'b1, 6'd16}) begin
      errors++;
      $display("FAIL bel_ignored: got wr_en=%b ready=%b cursor=%0d expected 0 1 16",
               bus.wr_en, bus.char_ready, bus.cursor);
    end
    send(8'h7E);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b1, 6'd16, 8'h7E, 6'd17}) begin
      errors++;
      $display("FAIL tilde: got wr_en=%b addr=%0d data=%h cursor=%0d expected 1 16 7e 17",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
    send(8'h7F);
    checks++;
    if ({bus.wr_en, bus.cursor} !== {1'b0, 6'd17}) begin
      errors++;
      $display("FAIL del_ignored: got wr_en=%b cursor=%0d expected 0 17", bus.wr_en, bus.cursor);
    end
    send(8'h20);
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b1, 6'd17, 8'h20, 6'd18}) begin
      errors++;
      $display("FAIL space: got wr_en=%b addr=%0d data=%h cursor=%0d expected 1 17 20 18",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
  endtask

  task automatic test_ff_reset();
    int n;
    send(8'h0D);
    send(8'h0A);
    wait_idle();
    type_chars(6, 8'h66);
    checks++;
    if (bus.cursor !== 6'd30) begin
      errors++;
      $display("FAIL ff_setup: got cursor=%0d expected 30", bus.cursor);
    end
    send(8'h0C);
    checks++;
    if ({bus.wr_en, bus.busy, bus.char_ready, bus.cursor} !== {1'b0, 1'b1, 1'b0, 6'd0}) begin
      errors++;
      $display("FAIL ff_accept: got wr_en=%b busy=%b ready=%b cursor=%0d expected 0 1 0 0",
               bus.wr_en, bus.busy, bus.char_ready, bus.cursor);
    end
    n = 0;
    while (bus.wr_en !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i <= 20; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out} !== {1'b1, 6'(i), 8'h20}) begin
        errors++;
        $display("FAIL ff_clear[%0d]: got wr_en=%b addr=%0d data=%h expected 1 %0d 20",
                 i, bus.wr_en, bus.data_addr, bus.data_out, i);
      end
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.wr_en, bus.data_addr, bus.data_out, bus.cursor} !== {1'b0, 6'd0, 8'h00, 6'd0}) begin
      errors++;
      $display("FAIL ff_async_reset: got wr_en=%b addr=%0d data=%h cursor=%0d expected 0 0 00 0",
               bus.wr_en, bus.data_addr, bus.data_out, bus.cursor);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.wr_en !== 1'b0) begin
      errors++;
      $display("FAIL ff_reset_hold: got wr_en=%b expected 0", bus.wr_en);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.wr_en, bus.data_addr, bus.data_out} !== {1'b1, 6'(i), 8'h20}) begin
        errors++;
        $display("FAIL ff_restart[%0d]: got wr_en=%b addr=%0d data=%h expected 1 %0d 20",
                 i, bus.wr_en, bus.data_addr, bus.data_out, i);
      end
    end
    @(negedge clk);
    checks++;
    if ({bus.wr_en, bus.char_ready, bus.cursor} !== {1'b0, 1'b1, 6'd0}) begin
      errors++;
      $display("FAIL ff_restart_end: got wr_en=%b ready=%b cursor=%0d expected 0 1 0",
               bus.wr_en, bus.char_ready, bus.cursor);
    end
  endtask

  initial begin
    bus.char_valid = 1'b0;
    bus.char_in    = 8'h00;
    test_reset();
    test_back_to_back();
    test_row_wrap();
    test_screen_wrap();
    test_control_codes();
    test_ff_reset();
    checks++;
    if (stall_seen !== 1'b0) begin
      errors++;
      $display("FAIL ready_timeout: got stall=%b expected 0", stall_seen);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
